// File: rtl/wfg_wb_sequencer.sv
// Wishbone front-end for wfg_top: replays a register-write table after reset or on start,
// then passes an external master through. Sequencer and external cycles never overlap.
module wfg_wb_sequencer #(
  parameter int BUSW        = 32,
  parameter int NUM_ENTRIES = 8,
  parameter int IDXW        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  parameter int TIMEOUT     = 255,
  parameter int AUTO_START  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic [IDXW-1:0] tbl_idx_o,
  input  logic [BUSW-1:0] tbl_adr_i,
  input  logic [BUSW-1:0] tbl_dat_i,
  input  logic [BUSW-1:0] ext_adr_i,
  input  logic [BUSW-1:0] ext_datwr_i,
  input  logic            ext_we_i,
  input  logic            ext_stb_i,
  input  logic            ext_cyc_i,
  output logic [BUSW-1:0] ext_datrd_o,
  output logic            ext_ack_o,
  output logic [BUSW-1:0] wbm_adr_o,
  output logic [BUSW-1:0] wbm_datwr_o,
  output logic            wbm_we_o,
  output logic            wbm_stb_o,
  output logic            wbm_cyc_o,
  input  logic [BUSW-1:0] wbm_datrd_i,
  input  logic            wbm_ack_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int CNTW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;

  localparam logic [1:0] S_RESET    = (AUTO_START != 0) ? S_FETCH : S_PASS;
  localparam logic       BUSY_RESET = (AUTO_START != 0);

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_idx;
  logic [CNTW-1:0] r_cnt;
  logic [BUSW-1:0] r_adr;
  logic [BUSW-1:0] r_dat;
  logic            r_req;
  logic            r_pending;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_pass;
  logic            w_last;
  logic [CNTW-1:0] w_cnt_inc;
  logic            w_tmo;
  logic            w_start_go;

  assign w_pass     = (r_state == S_PASS);
  assign w_last     = (r_idx == IDXW'(NUM_ENTRIES - 1));
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_tmo      = (w_cnt_inc == CNTW'(TIMEOUT));
  // A start (fresh or queued) only takes the bus once the external master is idle.
  assign w_start_go = (start_i || r_pending) && !ext_cyc_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_req     <= 1'b0;
      r_pending <= 1'b0;
      r_busy    <= BUSY_RESET;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_adr   <= tbl_adr_i;
          r_dat   <= tbl_dat_i;
          r_req   <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_ACK;
        end
        S_ACK: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (wbm_ack_i) begin
            r_req <= 1'b0;
            if (w_last) begin
              r_state <= S_PASS;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_PASS;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_PASS: begin
          if (w_start_go) begin
            r_state   <= S_FETCH;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end else if (start_i) begin
            r_pending <= 1'b1;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_PASS;
        end
      endcase
    end
  end

  assign tbl_idx_o   = r_idx;
  assign wbm_adr_o   = w_pass ? ext_adr_i   : r_adr;
  assign wbm_datwr_o = w_pass ? ext_datwr_i : r_dat;
  assign wbm_we_o    = w_pass ? ext_we_i    : r_req;
  assign wbm_stb_o   = w_pass ? ext_stb_i   : r_req;
  assign wbm_cyc_o   = w_pass ? ext_cyc_i   : r_req;
  assign ext_datrd_o = w_pass ? wbm_datrd_i : '0;
  assign ext_ack_o   = w_pass & wbm_ack_i;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_wfg_wb_sequencer.sv
// Bench for wfg_wb_sequencer: bus-level model of the sequencer plus a memory slave,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wfg_wb_sequencer;
  localparam int BUSW = 32;
  localparam int N    = 3;
  localparam int IDXW = 2;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start_i = 1'b0;
  logic [IDXW-1:0] tbl_idx_o;
  logic [BUSW-1:0] tbl_adr_i, tbl_dat_i;
  logic [BUSW-1:0] ext_adr_i = '0, ext_datwr_i = '0;
  logic            ext_we_i = 1'b0, ext_stb_i = 1'b0, ext_cyc_i = 1'b0;
  logic [BUSW-1:0] ext_datrd_o;
  logic            ext_ack_o;
  logic [BUSW-1:0] wbm_adr_o, wbm_datwr_o;
  logic            wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic [BUSW-1:0] wbm_datrd_i = '0;
  logic            wbm_ack_i = 1'b0;
  logic            busy_o, done_o, err_o;

  logic [31:0] tbl_a [0:N-1];
  logic [31:0] tbl_d [0:N-1];
  assign tbl_adr_i = (tbl_idx_o < IDXW'(N)) ? tbl_a[tbl_idx_o] : '0;
  assign tbl_dat_i = (tbl_idx_o < IDXW'(N)) ? tbl_d[tbl_idx_o] : '0;

  wfg_wb_sequencer #(.BUSW(BUSW), .NUM_ENTRIES(N), .TIMEOUT(TMO), .AUTO_START(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .tbl_idx_o(tbl_idx_o),
    .tbl_adr_i(tbl_adr_i), .tbl_dat_i(tbl_dat_i),
    .ext_adr_i(ext_adr_i), .ext_datwr_i(ext_datwr_i), .ext_we_i(ext_we_i),
    .ext_stb_i(ext_stb_i), .ext_cyc_i(ext_cyc_i),
    .ext_datrd_o(ext_datrd_o), .ext_ack_o(ext_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_datwr_o(wbm_datwr_o), .wbm_we_o(wbm_we_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_datrd_i(wbm_datrd_i), .wbm_ack_i(wbm_ack_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  // Model: sequence running? gap = the one idle bus cycle before each write.
  bit          m_seq, m_gap, m_done, m_err, m_pend;
  int          m_idx, m_age;
  logic [31:0] m_adr, m_dat;

  // Memory slave with per-transaction ack latency; s_hang never acks that address.
  int          s_age, s_lat, s_fix;
  logic [31:0] s_hang;
  logic [31:0] mem [0:63];

  // Staged external master / start inputs, applied just after each rising edge.
  logic        e_cyc, e_stb, e_we, e_start;
  logic [31:0] e_adr, e_dat;
  int          e_wait;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  bit          last_ext_ack;
  logic [31:0] last_ext_datrd;
  int          cyc_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic int pick_lat();
    int r;
    if (s_fix >= 0) return s_fix;
    r = int'($urandom_range(0, 19));
    if (r < 12) return r % 4;
    if (r == 12) return TMO - 1;
    if (r == 13) return TMO;
    if (r == 14) return TMO + 4;
    return int'($urandom_range(4, 12));
  endfunction

  task automatic model_reset();
    m_seq = 1'b1; m_gap = 1'b1; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
    m_idx = 0; m_age = 0;
    s_age = 0;
  endtask

  task automatic slave_compute();
    wbm_ack_i   = rst_n && wbm_cyc_o && wbm_stb_o && (s_age >= s_lat) && (wbm_adr_o !== s_hang);
    wbm_datrd_i = mem[wbm_adr_o[7:2]];
  endtask

  task automatic sample();
    if (rst_n) begin
      chk("busy", 32'(busy_o), 32'(m_seq));
      chk("done", 32'(done_o), 32'(m_done));
      chk("err", 32'(err_o), 32'(m_err));
      chk("tbl_idx", 32'(tbl_idx_o), 32'(m_idx));
      if (!m_seq) begin
        chk("pass_adr", wbm_adr_o, ext_adr_i);
        chk("pass_dat", wbm_datwr_o, ext_datwr_i);
        chk("pass_ctl", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, {29'd0, ext_cyc_i, ext_stb_i, ext_we_i});
        chk("pass_rd", ext_datrd_o, wbm_datrd_i);
        chk("pass_ack", 32'(ext_ack_o), 32'(wbm_ack_i));
      end else begin
        chk("seq_ext_ack", 32'(ext_ack_o), 32'd0);
        chk("seq_ext_rd", ext_datrd_o, 32'd0);
        chk("seq_ctl", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, m_gap ? 32'd0 : 32'd7);
        if (!m_gap) begin
          chk("seq_adr", wbm_adr_o, m_adr);
          chk("seq_dat", wbm_datwr_o, m_dat);
        end
      end
    end
    if (busy_o && wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i) begin
      log_a.push_back(wbm_adr_o);
      log_d.push_back(wbm_datwr_o);
    end
    last_ext_ack   = ext_ack_o;
    last_ext_datrd = ext_datrd_o;
    if (!m_seq) begin
      if ((start_i || m_pend) && !ext_cyc_i) begin
        m_seq = 1'b1; m_gap = 1'b1; m_idx = 0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
      end else if (start_i) begin
        m_pend = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0; m_age = 0; m_adr = tbl_a[m_idx]; m_dat = tbl_d[m_idx];
    end else if (wbm_ack_i) begin
      if (m_idx == N - 1) begin
        m_seq = 1'b0; m_done = 1'b1;
      end else begin
        m_idx++; m_gap = 1'b1;
      end
    end else if (m_age + 1 == TMO) begin
      m_seq = 1'b0; m_err = 1'b1; m_done = 1'b0;
    end else begin
      m_age++;
    end
    if (wbm_cyc_o && wbm_stb_o) begin
      if (wbm_ack_i) begin
        if (wbm_we_o) mem[wbm_adr_o[7:2]] = wbm_datwr_o;
        s_age = 0;
        s_lat = pick_lat();
      end else begin
        s_age++;
      end
    end else begin
      s_age = 0;
    end
    cyc_n++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ext_cyc_i = e_cyc; ext_stb_i = e_stb; ext_we_i = e_we;
    ext_adr_i = e_adr; ext_datwr_i = e_dat; start_i = e_start;
    #1;
    slave_compute();
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 chk("rst_async_drop", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    model_reset();
    wbm_ack_i = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_flags", {30'd0, done_o, err_o}, 32'd0);
    chk("rst_idx", 32'(tbl_idx_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    slave_compute();
    cyc_n = 0;
    sample();
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit seen = 1'b0;
    bit fin = 1'b0;
    for (int i = 0; i < bound && !fin; i++) begin
      step();
      if (busy_o) seen = 1'b1;
      if (seen && !busy_o) fin = 1'b1;
    end
    chk(name, 32'(fin), 32'd1);
  endtask

  task automatic pulse_start();
    e_start = 1'b1;
    step();
    e_start = 1'b0;
  endtask

  initial begin
    int done_at, hang_cnt;
    bit got, found;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    tbl_a[0] = 32'h00; tbl_a[1] = 32'h04; tbl_a[2] = 32'h08;
    tbl_d[0] = 32'h01; tbl_d[1] = 32'hA5; tbl_d[2] = 32'hFF;
    s_fix = 1; s_lat = 1; s_hang = 32'hFFFF_FFFF;
    e_cyc = 1'b1; e_stb = 1'b1; e_we = 1'b0; e_adr = 32'h40; e_dat = '0; e_start = 1'b0; e_wait = 0;
    ext_cyc_i = 1'b1; ext_stb_i = 1'b1; ext_adr_i = 32'h40;
    cyc_n = 0;

    // Auto-start after reset with an external master already requesting.
    do_reset();
    done_at = -1;
    for (int i = 0; i < 30 && done_at < 0; i++) begin
      step();
      if (done_o) done_at = cyc_n - 1;
    end
    chk("done_latency", 32'(done_at), 32'd9);
    chk("auto_nwrites", 32'(log_a.size()), 32'd3);
    if (log_a.size() == 3) begin
      chk("auto_w0", {log_a[0][15:0], log_d[0][15:0]}, 32'h0000_0001);
      chk("auto_w1", {log_a[1][15:0], log_d[1][15:0]}, 32'h0004_00A5);
      chk("auto_w2", {log_a[2][15:0], log_d[2][15:0]}, 32'h0008_00FF);
    end
    e_cyc = 1'b0; e_stb = 1'b0;
    step();

    // External read through the passthrough.
    e_cyc = 1'b1; e_stb = 1'b1; e_we = 1'b0; e_adr = 32'h04;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (last_ext_ack) begin
        got = 1'b1;
        chk("ext_read_a5", last_ext_datrd, 32'hA5);
      end
    end
    chk("ext_read_acked", 32'(got), 32'd1);
    e_cyc = 1'b0; e_stb = 1'b0;
    step();

    // Slave never acks entry 1.
    s_hang = 32'h04;
    log_a.delete(); log_d.delete();
    pulse_start();
    hang_cnt = 0;
    begin
      bit seen = 1'b0;
      bit fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
        step();
        if (busy_o) seen = 1'b1;
        if (busy_o && wbm_cyc_o && wbm_adr_o == 32'h04) hang_cnt++;
        if (seen && !busy_o) fin = 1'b1;
      end
      chk("tmo_finished", 32'(fin), 32'd1);
    end
    chk("tmo_ack_cycles", 32'(hang_cnt), 32'd16);
    chk("tmo_flags", {30'd0, err_o, done_o}, 32'd2);
    chk("tmo_nwrites", 32'(log_a.size()), 32'd1);
    s_hang = 32'hFFFF_FFFF;

    // Start while an external cycle is open: deferred until cyc drops.
    log_a.delete(); log_d.delete();
    e_cyc = 1'b1; e_stb = 1'b1; e_adr = 32'h40;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pend_hold_busy", 32'(busy_o), 32'd0);
    end
    e_cyc = 1'b0; e_stb = 1'b0;
    step();
    chk("pend_release_busy", 32'(busy_o), 32'd0);
    step();
    chk("pend_fetch_busy", 32'(busy_o), 32'd1);
    chk("pend_flags_clr", {30'd0, err_o, done_o}, 32'd0);
    wait_idle("pend_finished", 40);
    chk("pend_nwrites", 32'(log_a.size()), 32'd3);
    chk("pend_done", 32'(done_o), 32'd1);

    // Reset during the ack phase of entry 1.
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (busy_o && wbm_cyc_o && wbm_adr_o == 32'h04) found = 1'b1;
    end
    chk("rst_found_entry1", 32'(found), 32'd1);
    do_reset();
    log_a.delete(); log_d.delete();
    wait_idle("rst_rerun_finished", 40);
    chk("rst_rerun_nwrites", 32'(log_a.size()), 32'd3);
    if (log_a.size() > 0) chk("rst_rerun_first_adr", log_a[0], 32'h00);

    // Start during entry 0 ack is dropped.
    log_a.delete(); log_d.delete();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (busy_o && wbm_cyc_o && wbm_adr_o == 32'h00) found = 1'b1;
    end
    chk("ign_found_entry0", 32'(found), 32'd1);
    pulse_start();
    wait_idle("ign_finished", 40);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ign_no_rerun", 32'(busy_o), 32'd0);
    end
    chk("ign_nwrites", 32'(log_a.size()), 32'd3);

    // Randomized traffic, starts, latencies, table contents and resets.
    s_fix = -1;
    for (int n = 0; n < 1500; n++) begin
      if (!e_cyc) begin
        if ($urandom_range(0, 3) == 0) begin
          e_cyc = 1'b1; e_stb = 1'b1; e_we = 1'($urandom_range(0, 1));
          e_adr = 32'($urandom_range(0, 15)) << 2; e_dat = $urandom; e_wait = 0;
        end
      end else if (last_ext_ack || e_wait > 40) begin
        e_cyc = 1'b0; e_stb = 1'b0;
      end else begin
        e_wait++;
      end
      e_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) begin
        int k = int'($urandom_range(0, N - 1));
        tbl_a[k] = 32'($urandom_range(0, 15)) << 2;
        tbl_d[k] = $urandom;
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end
    e_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
